axi_read_responder: RTL and testbench
=====================================

# axi_read_responder

AXI4 read-channel responder (slave) that answers instruction and data-fetch read requests from the pipeline's AXI read initiator. It accepts one AR request at a time, generates FIXED/INCR/WRAP burst beat addresses, and reads 64-bit words from a synchronous single-port SRAM with 1-cycle read latency. It returns R beats through a 2-entry output buffer, sustaining 1 beat/cycle under full RREADY. It sits between the core's AXI master port and the simulation/on-chip memory.

## Interface
- MEM_AW, 16: SRAM word-address width (64-bit words; capacity 8·2^MEM_AW bytes).
- BASE_ADDR, 64'h8000_0000: byte address mapped to SRAM word 0.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- ARID  in  4  request ID.
- ARADDR  in  64  start byte address.
- ARLEN  in  8  beats minus one.
- ARSIZE  in  3  log2(bytes per beat).
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARVALID  in  1  request valid.
- ARREADY  out  1  request accepted; registered.
- RID  out  4  echo of accepted ARID.
- RDATA  out  64  full SRAM word containing the beat address.
- RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- RLAST  out  1  final beat of burst.
- RVALID  out  1  beat valid.
- RREADY  in  1  initiator accepts beat.
- mem_ren  out  1  SRAM read enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  64  SRAM data, valid the cycle after mem_ren.

## Operation
- States: IDLE, BURST.
  - IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ID/ADDR/LEN/SIZE/BURST, set issue counter = ARLEN+1, classify the request, go to BURST, and drop ARREADY at the same edge.
  - BURST: issue beats in order; exit to IDLE at the edge where the RLAST beat handshakes (RVALID&&RREADY&&RLAST). ARREADY rises at that same edge.
- Request errors, decided at acceptance:
  - ARSIZE>3, ARBURST==11, or WRAP with ARLEN not in {1,3,7,15} → every beat returns SLVERR.
  - Error beats still return exactly ARLEN+1 beats with RLAST on the final one, RDATA=0, and mem_ren=0.
- Beat address, with sz = 1<<ARSIZE:
  - FIXED: all beats use ARADDR.
  - INCR: beat0 = ARADDR; beat k = (ARADDR & ~(sz-1)) + k·sz, 64-bit wrap-around.
  - WRAP: boundary B = sz·(ARLEN+1), lower = ARADDR & ~(B-1); next = lower + ((cur + sz − lower) mod B).
- Per-beat decode:
  - Address outside [BASE_ADDR, BASE_ADDR+8·2^MEM_AW) → DECERR, RDATA=0, no mem_ren; other beats of the burst are unaffected.
  - Otherwise mem_addr = (addr − BASE_ADDR)[MEM_AW+2:3] and RRESP=OKAY.
- Issue rule:
  - A beat (memory or error) is issued in a cycle when beats remain and (buffer occupancy + beats in flight − pop this cycle) < 2.
  - In-flight beats land in the buffer on the next edge.
  - The buffer is a FIFO of {data, resp, last}; its head drives the R channel. RID is constant for the burst.
- R outputs stay stable while RVALID && !RREADY (AXI hold rule).

## Timing
- Reset asserted (async, immediate): ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, mem_ren=0, mem_addr=0; state=IDLE; buffer and counters cleared.
- First posedge after rst deasserts: ARREADY=1.
- Reset mid-burst: the burst is abandoned and no further beats are emitted.
- AR handshake at edge N: mem_ren for beat0 is high in cycle N..N+1; RVALID is high from edge N+2.
- First-beat latency: 2 cycles. Throughput: 1 beat/cycle with RREADY=1.
- Next AR can be accepted 1 cycle after the RLAST handshake edge.
- RREADY low: at most 2 buffered beats and no new mem_ren once full. The buffer never overflows.
- mem_rdata is sampled only on the edge after the matching mem_ren.

## Test plan
- SRAM[0]=64'h0000_0013_0000_0093; AR INCR len0 size2 at 0x8000_0000 → one beat, RDATA=that word, RRESP=00, RLAST=1, RVALID 2 cycles after AR; ARREADY back next cycle.
- INCR len3 size3 at 0x8000_0010 with RREADY toggling 1,0,0,1,…; SRAM[k]=k → RDATA 2,3,4,5 in order, RLAST only on 4th beat, outputs held while RREADY=0, ≤2 mem_ren ahead.
- WRAP len3 size3 at 0x8000_0018 → word addresses 3,0,1,2. WRAP len2 → 3 SLVERR beats, no mem_ren.
- FIXED len2 size2 at 0x8000_0004 → 3 beats all word 0. ARSIZE=4 → SLVERR.
- INCR len1 size3 at BASE_ADDR+8·2^MEM_AW−8 → beat0 OKAY, beat1 DECERR RDATA=0. ARADDR=0x0 → DECERR with RLAST.
- Assert rst during beat 2 of a len7 burst → RVALID and ARREADY drop immediately; after release a fresh len0 request completes normally with the correct RID.

Source files
------------

// File: rtl/axi_read_responder_if.sv
// AXI4 read-address / read-data channels plus the synchronous SRAM read port
// served by axi_read_responder.
interface axi_read_responder_if #(
    parameter int MEM_AW = 16
);
    logic [3:0]        ARID;
    logic [63:0]       ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [3:0]        RID;
    logic [63:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    logic              mem_ren;
    logic [MEM_AW-1:0] mem_addr;
    logic [63:0]       mem_rdata;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, mem_rdata,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID, mem_ren, mem_addr
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY, mem_rdata,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID, mem_ren, mem_addr
    );
endinterface

// File: rtl/axi_read_responder.sv
// AXI4 read responder: one outstanding AR burst, FIXED/INCR/WRAP beat addressing,
// 1-cycle-latency SRAM reads, and a 2-entry R buffer sustaining one beat per cycle.
module axi_read_responder #(
    parameter int          MEM_AW    = 16,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_read_responder_if.slave  io_axi
);
    localparam logic [63:0] MEM_BYTES   = 64'd8 << MEM_AW;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [1:0]  BURST_RSVD  = 2'b11;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    state_t      r_state, w_state_nxt;
    logic        r_arready, w_arready_nxt;

    logic [3:0]  r_id;
    logic [63:0] r_addr, r_sz, r_wmask, r_lower;
    logic [1:0]  r_burst;
    logic        r_err;
    logic [8:0]  r_cnt;

    logic        r_vld_p1, r_mem_p1, r_last_p1;
    logic [1:0]  r_resp_p1;

    logic [1:0]  r_occ;
    beat_t       r_buf0, r_buf1;

    logic        w_ar_hs, w_pop, w_last_hs, w_ar_err;
    logic        w_issue_p0, w_in_range_p0, w_mem_p0;
    logic [1:0]  w_resp_p0;
    logic [63:0] w_ar_sz, w_ar_bnd, w_off_p0;
    beat_t       w_land;

    function automatic logic [63:0] f_next_addr(input logic [1:0]  burst,
                                                input logic [63:0] cur,
                                                input logic [63:0] sz,
                                                input logic [63:0] lower,
                                                input logic [63:0] wmask);
        case (burst)
            BURST_INCR: f_next_addr = (cur & ~(sz - 64'd1)) + sz;
            BURST_WRAP: f_next_addr = lower + ((cur + sz - lower) & wmask);
            default:    f_next_addr = cur;
        endcase
    endfunction

    assign w_ar_hs   = (r_state == S_IDLE) && r_arready && io_axi.ARVALID;
    assign w_pop     = (r_occ != 2'd0) && io_axi.RREADY;
    assign w_last_hs = w_pop && r_buf0.last;

    // Request classification at acceptance; the wrap boundary is a power of two for legal WRAPs
    assign w_ar_sz  = 64'd1 << io_axi.ARSIZE;
    assign w_ar_bnd = ({56'd0, io_axi.ARLEN} + 64'd1) << io_axi.ARSIZE;
    assign w_ar_err = (io_axi.ARSIZE > 3'd3) || (io_axi.ARBURST == BURST_RSVD) ||
                      ((io_axi.ARBURST == BURST_WRAP) &&
                       !((io_axi.ARLEN == 8'd1) || (io_axi.ARLEN == 8'd3) ||
                         (io_axi.ARLEN == 8'd7) || (io_axi.ARLEN == 8'd15)));

    always_comb begin
        w_state_nxt   = r_state;
        w_arready_nxt = r_arready;
        case (r_state)
            S_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_ar_hs) begin
                    w_state_nxt   = S_BURST;
                    w_arready_nxt = 1'b0;
                end
            end
            S_BURST: begin
                if (w_last_hs) begin
                    w_state_nxt   = S_IDLE;
                    w_arready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_arready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
        end
    end

    // Stage p0: issue a beat only if it is guaranteed a buffer slot when it lands
    assign w_issue_p0    = (r_state == S_BURST) && (r_cnt != 9'd0) &&
                           (({1'b0, r_occ} + {2'b00, r_vld_p1} - {2'b00, w_pop}) < 3'd2);
    assign w_off_p0      = r_addr - BASE_ADDR;
    assign w_in_range_p0 = (r_addr >= BASE_ADDR) && (w_off_p0 < MEM_BYTES);
    assign w_mem_p0      = w_issue_p0 && !r_err && w_in_range_p0;
    assign w_resp_p0     = r_err ? RESP_SLVERR : (w_in_range_p0 ? RESP_OKAY : RESP_DECERR);

    assign io_axi.mem_ren  = w_mem_p0;
    assign io_axi.mem_addr = w_mem_p0 ? w_off_p0[MEM_AW+2:3] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_sz    <= '0;
            r_wmask <= '0;
            r_lower <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_ar_hs) begin
            r_id    <= io_axi.ARID;
            r_addr  <= io_axi.ARADDR;
            r_sz    <= w_ar_sz;
            r_wmask <= w_ar_bnd - 64'd1;
            r_lower <= io_axi.ARADDR & ~(w_ar_bnd - 64'd1);
            r_burst <= io_axi.ARBURST;
            r_err   <= w_ar_err;
            r_cnt   <= {1'b0, io_axi.ARLEN} + 9'd1;
        end else if (w_issue_p0) begin
            r_cnt   <= r_cnt - 9'd1;
            r_addr  <= f_next_addr(r_burst, r_addr, r_sz, r_lower, r_wmask);
        end
    end

    // Stage p1: SRAM access in flight; error beats carry no memory data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_mem_p1  <= 1'b0;
            r_resp_p1 <= '0;
            r_last_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_issue_p0;
            r_mem_p1  <= w_mem_p0;
            r_resp_p1 <= w_resp_p0;
            r_last_p1 <= (r_cnt == 9'd1);
        end
    end

    assign w_land.data = r_mem_p1 ? io_axi.mem_rdata : 64'd0;
    assign w_land.resp = r_resp_p1;
    assign w_land.last = r_last_p1;

    // Stage p2: 2-entry FIFO, slot 0 is the head and only moves on pop or push-into-empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= '0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({r_vld_p1, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_buf0 <= w_land;
                    else               r_buf1 <= w_land;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= w_land;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_land;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_axi.ARREADY = r_arready;
    assign io_axi.RVALID  = (r_occ != 2'd0);
    assign io_axi.RDATA   = r_buf0.data;
    assign io_axi.RRESP   = r_buf0.resp;
    assign io_axi.RLAST   = r_buf0.last;
    assign io_axi.RID     = r_id;
endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: directed and randomized bursts compared beat by beat
// against a burst-level reference model of the address and response rules.
module tb_axi_read_responder;
    localparam int          MEM_AW = 8;
    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam logic [63:0] LIM    = 64'd8 << MEM_AW;
    localparam logic [1:0]  FIXED  = 2'b00;
    localparam logic [1:0]  INCR   = 2'b01;
    localparam logic [1:0]  WRAP   = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_read_responder_if #(.MEM_AW(MEM_AW)) bus ();
    axi_read_responder #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_axi (bus)
    );

    logic [63:0]       sram [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0] ren_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_ren    = 0;
    int                n_pop    = 0;
    bit                ovf_seen = 1'b0;

    // Synchronous SRAM model plus outstanding-beat monitor
    always @(posedge clk) begin
        if (bus.mem_ren) begin
            bus.mem_rdata <= sram[bus.mem_addr];
            ren_q.push_back(bus.mem_addr);
        end else begin
            bus.mem_rdata <= 'x;
        end
        if (rst) begin
            n_ren = 0;
            n_pop = 0;
        end else begin
            n_ren = n_ren + int'(bus.mem_ren);
            n_pop = n_pop + int'(bus.RVALID && bus.RREADY);
            if (n_ren - n_pop > 2) ovf_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int mode, input int abort_at);
        logic [63:0]       exp_data[$];
        logic [1:0]        exp_resp[$];
        logic [MEM_AW-1:0] exp_ren[$];
        logic [63:0]       sz, bnd, lower, cur, a, h_data;
        logic [1:0]        h_resp;
        logic              h_last, rr;
        logic [MEM_AW-1:0] widx;
        bit                err, hs, done, stalled, seen_v;
        int                ren_base, idx, nr;

        sz    = 64'd1 << size;
        bnd   = sz * ({56'd0, len} + 64'd1);
        lower = addr - (addr % bnd);
        err   = (size > 3'd3) || (burst == 2'b11) ||
                (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        cur   = addr;
        for (int k = 0; k <= int'(len); k++) begin
            if (burst == INCR) a = (k == 0) ? addr : (addr - (addr % sz)) + 64'(k) * sz;
            else               a = cur;
            if (burst == WRAP) cur = lower + ((cur + sz - lower) % bnd);
            if (err) begin
                exp_resp.push_back(2'b10);
                exp_data.push_back(64'd0);
            end else if (a < BASE || a >= BASE + LIM) begin
                exp_resp.push_back(2'b11);
                exp_data.push_back(64'd0);
            end else begin
                widx = MEM_AW'((a - BASE) >> 3);
                exp_resp.push_back(2'b00);
                exp_data.push_back(sram[widx]);
                exp_ren.push_back(widx);
            end
        end

        ren_base = ren_q.size();
        @(negedge clk);
        bus.ARID    = id;
        bus.ARADDR  = addr;
        bus.ARLEN   = len;
        bus.ARSIZE  = size;
        bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        hs = 1'b0;
        for (int t = 0; t < 10 && !hs; t++) begin
            if (bus.ARREADY) hs = 1'b1;
            else @(negedge clk);
        end
        chk("ar_accept", 64'(hs), 64'd1);
        if (!hs) begin
            bus.ARVALID = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.ARVALID = 1'b0;
        chk("arready_drop", 64'(bus.ARREADY), 64'd0);

        idx = 0; done = 1'b0; stalled = 1'b0; seen_v = 1'b0;
        h_data = '0; h_resp = '0; h_last = 1'b0;
        for (int j = 0; j < 400 && !done; j++) begin
            @(negedge clk);
            if (j == 0) chk("ren_beat0", 64'(bus.mem_ren), 64'(exp_resp[0] == 2'b00));
            if (bus.RVALID && !seen_v) begin
                seen_v = 1'b1;
                chk("first_latency", 64'(j), 64'd2);
            end
            if (abort_at >= 0 && idx == abort_at && bus.RVALID) begin
                rst = 1'b1;
                bus.RREADY = 1'b0;
                #1;
                chk("rst_rvalid", 64'(bus.RVALID), 64'd0);
                chk("rst_arready", 64'(bus.ARREADY), 64'd0);
                chk("rst_rdata", bus.RDATA, 64'd0);
                chk("rst_mem_ren", 64'(bus.mem_ren), 64'd0);
                return;
            end
            if (stalled) begin
                chk("hold_data", bus.RDATA, h_data);
                chk("hold_ctl", {59'd0, bus.RVALID, bus.RRESP, bus.RLAST, bus.RID[0]},
                                {59'd0, 1'b1, h_resp, h_last, id[0]});
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = ((j + 2) % 4 == 0) || ((j + 2) % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            bus.RREADY = rr;
            stalled = bus.RVALID && !rr;
            if (stalled) begin
                h_data = bus.RDATA;
                h_resp = bus.RRESP;
                h_last = bus.RLAST;
            end
            if (bus.RVALID && rr) begin
                chk("rdata", bus.RDATA, exp_data[idx]);
                chk("rresp", 64'(bus.RRESP), 64'(exp_resp[idx]));
                chk("rlast", 64'(bus.RLAST), 64'(idx == int'(len)));
                chk("rid", 64'(bus.RID), 64'(id));
                idx++;
                done = (idx == int'(len) + 1);
            end
        end
        chk("burst_done", 64'(done), 64'd1);

        @(negedge clk);
        bus.RREADY = 1'b0;
        chk("arready_back", 64'(bus.ARREADY), 64'd1);
        chk("rvalid_idle", 64'(bus.RVALID), 64'd0);
        nr = ren_q.size() - ren_base;
        chk("ren_count", 64'(nr), 64'(exp_ren.size()));
        for (int i = 0; i < nr && i < exp_ren.size(); i++)
            chk("ren_addr", 64'(ren_q[ren_base + i]), 64'(exp_ren[i]));
    endtask

    initial begin
        logic [1:0]  b;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [63:0] ad;

        rst         = 1'b1;
        bus.ARID    = '0;
        bus.ARADDR  = '0;
        bus.ARLEN   = '0;
        bus.ARSIZE  = '0;
        bus.ARBURST = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
        for (int k = 0; k < (1 << MEM_AW); k++) sram[k] = 64'(k);

        repeat (3) @(negedge clk);
        chk("reset_arready", 64'(bus.ARREADY), 64'd0);
        chk("reset_rvalid", 64'(bus.RVALID), 64'd0);
        chk("reset_rlast", 64'(bus.RLAST), 64'd0);
        chk("reset_rresp", 64'(bus.RRESP), 64'd0);
        chk("reset_rid", 64'(bus.RID), 64'd0);
        chk("reset_rdata", bus.RDATA, 64'd0);
        chk("reset_mem_ren", 64'(bus.mem_ren), 64'd0);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arready_after_rst", 64'(bus.ARREADY), 64'd1);

        sram[0] = 64'h0000_0013_0000_0093;
        do_burst(4'h5, BASE, 8'd0, 3'd2, INCR, 0, -1);
        sram[0] = 64'd0;
        do_burst(4'h6, BASE + 64'h10, 8'd3, 3'd3, INCR, 1, -1);
        do_burst(4'h7, BASE + 64'h18, 8'd3, 3'd3, WRAP, 0, -1);
        do_burst(4'h8, BASE + 64'h18, 8'd2, 3'd3, WRAP, 1, -1);
        do_burst(4'h9, BASE + 64'h4, 8'd2, 3'd2, FIXED, 1, -1);
        do_burst(4'hA, BASE + 64'h10, 8'd1, 3'd4, INCR, 0, -1);
        do_burst(4'hB, BASE + LIM - 64'd8, 8'd1, 3'd3, INCR, 2, -1);
        do_burst(4'hC, 64'h0, 8'd0, 3'd3, INCR, 0, -1);
        do_burst(4'h1, BASE + 64'h20, 8'd2, 3'd3, 2'b11, 2, -1);

        for (int r = 0; r < 30; r++) begin
            for (int q = 0; q < 8; q++) sram[$urandom_range(0, (1 << MEM_AW) - 1)] = {$urandom, $urandom};
            b  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            s  = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            if (b == WRAP && $urandom_range(0, 4) != 0) l = 8'((1 << $urandom_range(1, 4)) - 1);
            else                                        l = 8'($urandom_range(0, 15));
            ad = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                             : BASE + 64'($urandom_range(0, (1 << (MEM_AW + 3)) - 1));
            do_burst(4'($urandom_range(0, 15)), ad, l, s, b, int'($urandom_range(0, 2)), -1);
        end

        do_burst(4'hD, BASE, 8'd7, 3'd3, INCR, 0, 2);
        repeat (2) @(negedge clk);
        chk("rst_hold_rvalid", 64'(bus.RVALID), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arready_after_abort", 64'(bus.ARREADY), 64'd1);
        do_burst(4'h3, BASE + 64'h28, 8'd0, 3'd3, INCR, 0, -1);

        chk("no_overflow", 64'(ovf_seen), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
